// File: rtl/exec_ctrl_pkg.sv
// Shared encodings for the execution controller: FSM states, halt causes and the EBREAK opcode.
package exec_ctrl_pkg;

  typedef enum logic [1:0] {
    StHalt = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CauseNone       = 2'd0,
    CauseHaltReq    = 2'd1,
    CauseBreakpoint = 2'd2,
    CauseEbreak     = 2'd3
  } cause_e;

  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

endpackage

// File: rtl/EventCounter.sv
// Wrapping event counter with synchronous clear (clear beats increment) and async reset.
module EventCounter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/exec_controller.sv
// Run/step/halt controller gating datapath commits, with breakpoint/ebreak stop and event counters.
module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter bit          START_RUNNING = 1'b0,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic                 bp_en,
  input  logic [31:0]          bp_addr,
  input  logic [31:0]          pc,
  input  logic [31:0]          instr,
  input  logic                 clr_cnt,
  output logic                 commit_en,
  output logic [1:0]           state,
  output logic                 halted,
  output logic [1:0]           halt_cause,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] retired_cnt
);

  state_e r_state, w_state_next;
  cause_e r_cause, w_cause_next;
  // Set for the first RUN cycle after HALT so a resume at a breakpoint/ebreak commits it once.
  logic   r_first, w_first_next;
  logic   w_bp_hit, w_ebreak, w_stop, w_commit;

  always_comb begin
    w_bp_hit     = bp_en && (pc == bp_addr);
    w_ebreak     = (instr == EBREAK_INSTR);
    w_state_next = r_state;
    w_cause_next = r_cause;
    w_first_next = 1'b0;
    w_stop       = 1'b0;
    w_commit     = 1'b0;
    unique case (r_state)
      StHalt: begin
        if (step_req) begin
          w_state_next = StStep;
          w_cause_next = CauseNone;
        end else if (run_req) begin
          w_state_next = StRun;
          w_cause_next = CauseNone;
          w_first_next = 1'b1;
        end
      end
      StRun: begin
        w_stop   = halt_req || (!r_first && (w_bp_hit || w_ebreak));
        w_commit = !w_stop;
        if (w_stop) begin
          w_state_next = StHalt;
          if (halt_req) begin
            w_cause_next = CauseHaltReq;
          end else if (w_bp_hit) begin
            w_cause_next = CauseBreakpoint;
          end else begin
            w_cause_next = CauseEbreak;
          end
        end
      end
      StStep: begin
        w_commit     = 1'b1;
        w_state_next = StHalt;
        w_cause_next = CauseHaltReq;
      end
      default: begin
        w_state_next = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= START_RUNNING ? StRun : StHalt;
      r_cause <= CauseNone;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cause <= w_cause_next;
      r_first <= w_first_next;
    end
  end

  assign commit_en  = w_commit && !reset;
  assign state      = r_state;
  assign halted     = (r_state == StHalt);
  assign halt_cause = r_cause;

  EventCounter #(
    .WIDTH(CNT_WIDTH)
  ) u_cycle_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (1'b1),
    .clr  (clr_cnt),
    .count(cycle_cnt)
  );

  EventCounter #(
    .WIDTH(CNT_WIDTH)
  ) u_retired_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (commit_en),
    .clr  (clr_cnt),
    .count(retired_cnt)
  );

endmodule

// File: tb/tb_exec_controller.sv
// Scoreboard bench for exec_controller, plus a narrow-counter instance for wrap checks.
module tb_exec_controller;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk = 1'b0;
  logic        reset, run_req, step_req, halt_req, bp_en, clr_cnt;
  logic [31:0] bp_addr, pc, instr;
  logic        commit_en, halted;
  logic [1:0]  state, halt_cause;
  logic [31:0] cycle_cnt, retired_cnt;

  logic        w_rst;
  logic        w_commit, w_halted;
  logic [1:0]  w_state, w_cause;
  logic [3:0]  w_cyc, w_ret;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    logic        commit;
    logic [1:0]  state;
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  logic [1:0]  m_state, m_cause;
  logic        m_first;
  logic [31:0] m_cyc, m_ret;

  always #5 clk = ~clk;

  exec_controller #(
    .START_RUNNING(1'b0),
    .CNT_WIDTH    (32)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .pc         (pc),
    .instr      (instr),
    .clr_cnt    (clr_cnt),
    .commit_en  (commit_en),
    .state      (state),
    .halted     (halted),
    .halt_cause (halt_cause),
    .cycle_cnt  (cycle_cnt),
    .retired_cnt(retired_cnt)
  );

  exec_controller #(
    .START_RUNNING(1'b1),
    .CNT_WIDTH    (4)
  ) u_dut_wrap (
    .clk        (clk),
    .reset      (w_rst),
    .run_req    (1'b0),
    .step_req   (1'b0),
    .halt_req   (1'b0),
    .bp_en      (1'b0),
    .bp_addr    (32'h0),
    .pc         (32'h0),
    .instr      (NOP),
    .clr_cnt    (1'b0),
    .commit_en  (w_commit),
    .state      (w_state),
    .halted     (w_halted),
    .halt_cause (w_cause),
    .cycle_cnt  (w_cyc),
    .retired_cnt(w_ret)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 2'd0;
    m_cause = 2'd0;
    m_first = 1'b0;
    m_cyc   = '0;
    m_ret   = '0;
  endtask

  task automatic sb_compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("commit_en", {31'd0, commit_en}, {31'd0, e.commit});
      check_eq("state", {30'd0, state}, {30'd0, e.state});
      check_eq("halted", {31'd0, halted}, {31'd0, (e.state == 2'd0)});
      check_eq("halt_cause", {30'd0, halt_cause}, {30'd0, e.cause});
      check_eq("cycle_cnt", cycle_cnt, e.cyc);
      check_eq("retired_cnt", retired_cnt, e.ret);
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input logic run, input logic step, input logic halt,
                      input logic [31:0] pc_v, input logic [31:0] instr_v, input logic clr);
    exp_t e;
    logic bp, eb, stop;
    run_req  = run;
    step_req = step;
    halt_req = halt;
    pc       = pc_v;
    instr    = instr_v;
    clr_cnt  = clr;
    #2;
    bp   = bp_en && (pc_v == bp_addr);
    eb   = (instr_v == EBREAK);
    stop = (m_state == 2'd1) && (halt || (!m_first && (bp || eb)));
    e.commit = (m_state == 2'd2) || ((m_state == 2'd1) && !stop);
    e.state  = m_state;
    e.cause  = m_cause;
    e.cyc    = m_cyc;
    e.ret    = m_ret;
    sb_q.push_back(e);
    sb_compare();
    @(posedge clk);
    m_cyc = clr ? 32'd0 : m_cyc + 32'd1;
    m_ret = clr ? 32'd0 : m_ret + {31'd0, e.commit};
    case (m_state)
      2'd0: begin
        if (step) begin
          m_state = 2'd2;
          m_cause = 2'd0;
        end else if (run) begin
          m_state = 2'd1;
          m_cause = 2'd0;
          m_first = 1'b1;
        end
      end
      2'd1: begin
        m_first = 1'b0;
        if (stop) begin
          m_state = 2'd0;
          m_cause = halt ? 2'd1 : (bp ? 2'd2 : 2'd3);
        end
      end
      default: begin
        m_state = 2'd0;
        m_cause = 2'd1;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [31:0] pc_v);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, pc_v, NOP, 1'b0);
  endtask

  initial begin
    reset = 1'b1; w_rst = 1'b1;
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; clr_cnt = 1'b0;
    bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0; instr = NOP;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_commit", {31'd0, commit_en}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd1);
    check_eq("rst_cause", {30'd0, halt_cause}, 32'd0);
    check_eq("rst_cycle", cycle_cnt, 32'd0);
    check_eq("rst_wrap_state", {30'd0, w_state}, 32'd1);
    reset = 1'b0; w_rst = 1'b0;

    // Idle in HALT, then narrow counter wraps
    idle(10, 32'h0);
    check_eq("idle_cycle10", cycle_cnt, 32'd10);
    check_eq("idle_retired0", retired_cnt, 32'd0);
    check_eq("idle_halted", {31'd0, halted}, 32'd1);
    idle(5, 32'h0);
    check_eq("wrap_cyc_f", {28'd0, w_cyc}, 32'hf);
    idle(1, 32'h0);
    check_eq("wrap_cyc_0", {28'd0, w_cyc}, 32'h0);
    check_eq("wrap_ret_0", {28'd0, w_ret}, 32'h0);
    check_eq("wrap_commit", {31'd0, w_commit}, 32'd1);
    check_eq("wrap_halted", {31'd0, w_halted}, 32'd0);
    check_eq("wrap_cause", {30'd0, w_cause}, 32'd0);

    // Single step; STEP ignores halt_req and ebreak
    tick(1'b0, 1'b0, 1'b0, 32'h08, NOP, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 32'h08, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 32'h08, EBREAK, 1'b0);
    idle(1, 32'h0c);
    check_eq("step_retired", retired_cnt, 32'd1);
    check_eq("step_cause", {30'd0, halt_cause}, 32'd1);

    // Breakpoint run
    bp_en = 1'b1; bp_addr = 32'h10;
    tick(1'b0, 1'b0, 1'b0, 32'h0, NOP, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 32'h0, NOP, 1'b0);
    for (int a = 0; a <= 16; a += 4) tick(1'b0, 1'b0, 1'b0, a, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 32'h10, NOP, 1'b0);
    check_eq("bp_retired4", retired_cnt, 32'd4);
    check_eq("bp_cause", {30'd0, halt_cause}, 32'd2);

    // Resume at breakpoint, then halt_req
    tick(1'b1, 1'b0, 1'b0, 32'h10, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h10, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h14, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 32'h18, NOP, 1'b0);
    check_eq("resume_retired", retired_cnt, 32'd6);
    check_eq("haltreq_cause", {30'd0, halt_cause}, 32'd1);

    // Ebreak stop, then halt_req beats breakpoint and ebreak
    tick(1'b1, 1'b0, 1'b0, 32'h20, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h20, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h24, EBREAK, 1'b0);
    check_eq("ebreak_cause", {30'd0, halt_cause}, 32'd3);
    tick(1'b1, 1'b0, 1'b0, 32'h28, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h28, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 32'h10, EBREAK, 1'b0);
    check_eq("prio_cause", {30'd0, halt_cause}, 32'd1);

    // Clear together with a commit
    tick(1'b1, 1'b0, 1'b0, 32'h30, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h30, NOP, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 32'h34, NOP, 1'b1);
    check_eq("clr_cycle", cycle_cnt, 32'd0);
    check_eq("clr_retired", retired_cnt, 32'd0);

    // Reset mid-RUN
    run_req = 1'b0; halt_req = 1'b0; clr_cnt = 1'b0; pc = 32'h38; instr = NOP;
    #1;
    check_eq("pre_rst_commit", {31'd0, commit_en}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("midrun_rst_commit", {31'd0, commit_en}, 32'd0);
    check_eq("midrun_rst_state", {30'd0, state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(2, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 Parameter START_RUNNING, default 0; 1 = leave reset in RUN, 0 = leave reset in HALT.
REQ-002 Parameter CNT_WIDTH, default 32; width of both event counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 run_req  input  1  one-cycle request to enter free-running execution.
REQ-006 step_req  input  1  one-cycle request to execute exactly one instruction.
REQ-007 halt_req  input  1  one-cycle request to stop execution.
REQ-008 bp_en  input  1  breakpoint enable.
REQ-009 bp_addr  input  32  breakpoint PC address.
REQ-010 pc  input  32  current program counter from the datapath.
REQ-011 instr  input  32  current instruction from instruction memory.
REQ-012 clr_cnt  input  1  synchronous clear of both counters.
REQ-013 commit_en  output  1  gates PC write enable, RegWrite and MemWrite of the datapath.
REQ-014 state  output  2  FSM state: HALT=0, RUN=1, STEP=2.
REQ-015 halted  output  1  high when state is HALT.
REQ-016 halt_cause  output  2  sticky reason for the last halt: 0 none/reset, 1 halt_req, 2 breakpoint, 3 ebreak.
REQ-017 cycle_cnt  output  CNT_WIDTH  clock cycles since reset or clear.
REQ-018 retired_cnt  output  CNT_WIDTH  cycles with commit_en high since reset or clear.

Function
REQ-019 commit_en SHALL be combinational: 0 in HALT; 1 in STEP; 1 in RUN unless a stop condition is present in the same cycle.
REQ-020 Stop condition in RUN SHALL be halt_req, or (bp_en and pc==bp_addr), or instr==32'h00100073 (ebreak).
REQ-021 A stopping instruction SHALL NOT commit: commit_en is 0 in the stop cycle, and the next state is HALT.
REQ-022 The stop cause SHALL be latched into halt_cause with priority halt_req > breakpoint > ebreak.
REQ-023 HALT: step_req -> STEP; else run_req -> RUN; step_req wins when both are asserted.
REQ-024 HALT: halt_req SHALL be ignored, and halt_cause is unchanged.
REQ-025 STEP SHALL last exactly one cycle with commit_en=1, then return to HALT regardless of breakpoint, ebreak or halt_req.
REQ-026 STEP SHALL leave halt_cause at 1 after its return to HALT.
REQ-027 Accepting run_req or step_req SHALL clear halt_cause to 0 on the transition edge.
REQ-028 RUN: breakpoint and ebreak stop conditions SHALL be masked in the first RUN cycle after leaving HALT, so that resuming at a breakpoint or ebreak commits that instruction once.
REQ-029 RUN: halt_req SHALL NOT be masked in the first RUN cycle.
REQ-030 run_req and step_req SHALL be ignored while in RUN.
REQ-031 cycle_cnt SHALL increment every cycle.
REQ-032 retired_cnt SHALL increment in every cycle where commit_en=1.
REQ-033 Both counters SHALL wrap modulo 2^CNT_WIDTH.
REQ-034 clr_cnt SHALL take priority over increment, giving 0 on the following cycle.
REQ-035 halted SHALL equal (state==HALT).

Reset
REQ-036 While reset is high, commit_en SHALL be forced to 0 asynchronously.
REQ-037 On reset: state = RUN if START_RUNNING=1, else HALT.
REQ-038 On reset: halt_cause=0 and cycle_cnt=retired_cnt=0.
REQ-039 On reset: the first-cycle mask SHALL be clear, so a breakpoint on the reset vector hits.
REQ-040 Reset asserted mid-RUN or mid-STEP SHALL abort the operation with no commit in that cycle.

Structure
REQ-041 A shared package exec_ctrl_pkg SHALL hold the state encodings, the halt_cause encodings and the EBREAK constant 32'h00100073.
REQ-042 One sub-module, EventCounter (parameter WIDTH; inputs inc and clr; asynchronous reset), SHALL be instantiated twice, once for each counter.

Verification
REQ-043 START_RUNNING=0, reset released, no requests for 10 cycles -> commit_en=0, halted=1, cycle_cnt=10, retired_cnt=0.
REQ-044 HALT, step_req pulse at pc=0x08 -> exactly one commit_en cycle, state 0->2->0, retired_cnt +1.
REQ-045 bp_en=1, bp_addr=0x10, run_req, pc advancing by 4 from 0 -> commits at 0x00, 0x04, 0x08 and 0x0C; commit_en=0 at 0x10; halt_cause=2; retired_cnt=4.
REQ-046 After REQ-045, run_req -> instruction at 0x10 commits and execution continues; halt_req pulse -> halt in that cycle with no commit, halt_cause=1.
REQ-047 RUN with instr=0x00100073 -> no commit, halt_cause=3; simultaneous halt_req and breakpoint -> halt_cause=1.
REQ-048 cycle_cnt preloaded to 0xFFFFFFFF -> wraps to 0; clr_cnt together with commit -> both counters 0; reset asserted mid-RUN -> commit_en=0 immediately.
